// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a word-wide data memory; sub-word stores use a two-cycle read-modify-write.
// Optional MAU_ALIGN_CHECK_EN: reject misaligned halfword/word requests and pulse Misaligned.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [31:0]       ReqWData,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [31:0]       MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [31:0]       MemReadData,
    output logic [31:0]       LoadData,
    output logic              LoadValid,
    output logic              Stall,
    output logic              Misaligned
);
    typedef enum logic {IDLE, RMW} state_t;

    state_t            state;
    logic [ADDR_W-1:0] rmw_addr_p1;
    logic [31:0]       rmw_data_p1;
    logic [31:0]       load_data_p1;
    logic              vld_p1;
    logic              accept;
    logic              ok;
    logic              is_word;
    logic              load;
    logic              word_store;
    logic              sub_store;
    logic [ADDR_W-1:0] word_addr;

    function automatic logic [31:0] extend_lane(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic sgn);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        if (size == 2'b00)
            r = sgn ? 32'(b) : {24'd0, b};
        else if (size == 2'b01)
            r = sgn ? 32'(h) : {16'd0, h};
        else
            r = word;
        return r;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] wdata,
                                               input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = word;
        if (size == 2'b00)
            r[{lane, 3'b000} +: 8] = wdata[7:0];
        else
            r[{lane[1], 4'b0000} +: 16] = wdata;
        return r;
    endfunction

    assign accept    = Req && (state == IDLE) && !Reset;
    assign is_word   = ReqSize[1];
    assign word_addr = {ReqAddr[ADDR_W-1:2], 2'b00};

`ifdef MAU_ALIGN_CHECK_EN
    logic misalign;
    logic misaligned_p1;
    assign misalign = (ReqSize == 2'b01) ? ReqAddr[0] :
                      (is_word ? (ReqAddr[1:0] != 2'b00) : 1'b0);

    always_ff @(posedge Clk) begin
        if (Reset)
            misaligned_p1 <= 1'b0;
        else
            misaligned_p1 <= accept && misalign;
    end
    assign Misaligned = misaligned_p1;
`else
    logic misalign;
    assign misalign   = 1'b0;
    assign Misaligned = 1'b0;
`endif

    assign ok         = accept && !misalign;
    assign load       = ok && !ReqWrite;
    assign word_store = ok && ReqWrite && is_word;
    assign sub_store  = ok && ReqWrite && !is_word;
    assign Stall      = (state == RMW);

    // Reset gates the pending RMW write so a dropped store never reaches memory.
    always_comb begin
        MemRead      = load || sub_store;
        MemWrite     = 1'b0;
        MemAddress   = '0;
        MemWriteData = '0;
        if (state == RMW) begin
            MemWrite     = !Reset;
            MemAddress   = rmw_addr_p1;
            MemWriteData = rmw_data_p1;
        end else if (ok) begin
            MemAddress   = word_addr;
            MemWrite     = word_store;
            MemWriteData = word_store ? ReqWData : '0;
        end
    end

    // Stage p1: extended load result, FSM state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            vld_p1       <= 1'b0;
            load_data_p1 <= '0;
        end else begin
            vld_p1 <= load;
            if (load)
                load_data_p1 <= extend_lane(MemReadData, ReqSize, ReqAddr[1:0], ReqSigned);
            state <= sub_store ? RMW : IDLE;
        end
    end

    // Stage p1: merged word and address held for the RMW write cycle
    always_ff @(posedge Clk) begin
        if (sub_store) begin
            rmw_addr_p1 <= word_addr;
            rmw_data_p1 <= merge_lane(MemReadData, ReqWData[15:0], ReqSize, ReqAddr[1:0]);
        end
    end

    assign LoadData  = load_data_p1;
    assign LoadValid = vld_p1;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed scenarios plus random traffic against a byte-lane memory model.
module tb_mem_access_unit;
    localparam int ADDR_W = 32;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Req;
    logic              ReqWrite;
    logic [1:0]        ReqSize;
    logic              ReqSigned;
    logic [ADDR_W-1:0] ReqAddr;
    logic [31:0]       ReqWData;
    logic [ADDR_W-1:0] MemAddress;
    logic [31:0]       MemWriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [31:0]       MemReadData;
    logic [31:0]       LoadData;
    logic              LoadValid;
    logic              Stall;
    logic              Misaligned;

    always #5 Clk = ~Clk;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .ReqWrite(ReqWrite), .ReqSize(ReqSize),
        .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemReadData(MemReadData), .LoadData(LoadData),
        .LoadValid(LoadValid), .Stall(Stall), .Misaligned(Misaligned)
    );

    // Data memory: asynchronous read, posedge write, 256 words.
    logic [31:0] mem [0:255] = '{default: 32'd0};
    assign MemReadData = mem[MemAddress[9:2]];
    always @(posedge Clk) if (MemWrite) mem[MemAddress[9:2]] <= MemWriteData;

    typedef struct {
        bit          mis;
        logic [31:0] data;
    } exp_t;

    logic [31:0] ref_mem [0:255];
    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
    endfunction

    function automatic bit is_mis(input logic [1:0] size, input logic [31:0] addr);
`ifdef MAU_ALIGN_CHECK_EN
        return (nbytes(size) == 2 && addr[0]) || (nbytes(size) == 4 && addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Byte offset of the accessed lane inside its word.
    function automatic int lane_off(input logic [1:0] size, input logic [31:0] addr);
        int n;
        n = nbytes(size);
        return (n == 4) ? 0 : ((int'(addr % 4) / n) * n);
    endfunction

    task automatic issue(input bit wr, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] data);
        int          tries;
        int          n;
        int          off;
        int          idx;
        logic [31:0] mask;
        logic [31:0] val;
        exp_t        e;
        tries = 0;
        @(negedge Clk);
        while (Stall && tries < 4) begin
            Req = 1'b0;
            tries++;
            @(negedge Clk);
        end
        if (Stall) check("stall_timeout", {31'd0, Stall}, 32'd0);
        Req = 1'b1; ReqWrite = wr; ReqSize = size; ReqSigned = sgn; ReqAddr = addr; ReqWData = data;
        n    = nbytes(size);
        off  = lane_off(size, addr);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        idx  = int'(addr[9:2]);
        if (is_mis(size, addr)) begin
            e.mis = 1'b1; e.data = 32'd0;
            sbq.push_back(e);
        end else if (!wr) begin
            val = (ref_mem[idx] >> (8 * off)) & mask;
            if (sgn && n < 4 && val[8 * n - 1]) val = val | ~mask;
            e.mis = 1'b0; e.data = val;
            sbq.push_back(e);
        end else begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((data & mask) << (8 * off));
        end
    endtask

    always @(posedge Clk) begin
        #1;
        if (LoadValid || Misaligned) begin
            if (sbq.size() == 0) begin
                check("unexpected_output", {30'd0, Misaligned, LoadValid}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("misaligned_kind", {31'd0, Misaligned}, {31'd0, mon_e.mis});
                if (!mon_e.mis) check("load_data", LoadData, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_rd;
        Reset = 1'b1; Req = 1'b0; ReqWrite = 1'b0; ReqSize = 2'd0; ReqSigned = 1'b0;
        ReqAddr = '0; ReqWData = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        repeat (3) @(negedge Clk);
        #1;
        check("rst_loadvalid", {31'd0, LoadValid}, 32'd0);
        check("rst_loaddata", LoadData, 32'd0);
        check("rst_stall", {31'd0, Stall}, 32'd0);
        check("rst_misaligned", {31'd0, Misaligned}, 32'd0);
        check("rst_memread", {31'd0, MemRead}, 32'd0);
        check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
        Reset = 1'b0;

        // Sign/zero extension of byte and halfword lanes.
        issue(1, 2'd2, 0, 32'h104, 32'h8899AABB);
        #1 check("wstore_memwrite", {31'd0, MemWrite}, 32'd1);
        issue(0, 2'd0, 1, 32'h107, 32'd0);
        #1;
        check("load_memread", {31'd0, MemRead}, 32'd1);
        check("load_addr", MemAddress, 32'h104);
        issue(0, 2'd0, 0, 32'h107, 32'd0);
        issue(0, 2'd1, 1, 32'h104, 32'd0);

        // Byte store read-modify-write.
        issue(1, 2'd2, 0, 32'h100, 32'h11223344);
        issue(1, 2'd0, 0, 32'h102, 32'h000000EE);
        #1;
        check("rmw_rd_memread", {31'd0, MemRead}, 32'd1);
        check("rmw_rd_memwrite", {31'd0, MemWrite}, 32'd0);
        check("rmw_rd_addr", MemAddress, 32'h100);
        @(negedge Clk);
        Req = 1'b0;
        #1;
        check("rmw_wr_stall", {31'd0, Stall}, 32'd1);
        check("rmw_wr_memwrite", {31'd0, MemWrite}, 32'd1);
        check("rmw_wr_memread", {31'd0, MemRead}, 32'd0);
        check("rmw_wr_data", MemWriteData, 32'h11EE3344);
        check("rmw_wr_addr", MemAddress, 32'h100);
        issue(0, 2'd2, 0, 32'h100, 32'd0);
        #1 check("after_rmw_stall", {31'd0, Stall}, 32'd0);

        // Halfword RMW with a request presented during the write cycle.
        issue(1, 2'd2, 0, 32'h100, 32'h11223344);
        issue(1, 2'd1, 0, 32'h102, 32'h0000BEEF);
        @(negedge Clk);
        Req = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd2; ReqAddr = 32'h100; ReqWData = 32'hDEADDEAD;
        #1;
        check("hw_rmw_stall", {31'd0, Stall}, 32'd1);
        check("hw_rmw_data", MemWriteData, 32'hBEEF3344);
        check("hw_rmw_memread", {31'd0, MemRead}, 32'd0);
        issue(0, 2'd2, 0, 32'h100, 32'd0);

        // Misaligned word load.
        issue(0, 2'd2, 0, 32'h102, 32'd0);
        exp_rd = !is_mis(2'd2, 32'h102);
        #1 check("misalign_memread", {31'd0, MemRead}, {31'd0, exp_rd});

        // Reset during the RMW write cycle drops the store.
        issue(1, 2'd2, 0, 32'h300, 32'h55667788);
        issue(1, 2'd0, 0, 32'h301, 32'h00000099);
        @(negedge Clk);
        Req = 1'b0; Reset = 1'b1;
        #1;
        check("rst_rmw_memwrite", {31'd0, MemWrite}, 32'd0);
        check("rst_rmw_memread", {31'd0, MemRead}, 32'd0);
        @(negedge Clk);
        #1;
        check("rst_rmw_stall", {31'd0, Stall}, 32'd0);
        check("rst_rmw_loadvalid", {31'd0, LoadValid}, 32'd0);
        check("rst_rmw_loaddata", LoadData, 32'd0);
        check("rst_rmw_misaligned", {31'd0, Misaligned}, 32'd0);
        Reset = 1'b0;
        ref_mem[8'hC0] = 32'h55667788;
        issue(0, 2'd2, 0, 32'h300, 32'd0);

        // Back-to-back store, load, load with no stalls.
        issue(1, 2'd2, 0, 32'h200, 32'hCAFEF00D);
        issue(0, 2'd2, 0, 32'h200, 32'd0);
        #1 check("b2b_stall1", {31'd0, Stall}, 32'd0);
        issue(0, 2'd0, 0, 32'h201, 32'd0);
        #1 check("b2b_stall2", {31'd0, Stall}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
                  32'($urandom % 1024), $urandom);
            if ($urandom % 5 == 0) begin
                @(negedge Clk);
                Req = 1'b0;
            end
        end

        @(negedge Clk);
        Req = 1'b0;
        repeat (5) @(negedge Clk);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
